// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator multi-cycle controller.
// Covers opcodes, datapath select codes, FSM states and opcode classification helpers.
package acc_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_JUMP  = 4'b0001;
    localparam logic [3:0] OP_SAVE  = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_LOADI = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_AND   = 4'b1010;
    localparam logic [3:0] OP_OR    = 4'b1011;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_SLT   = 4'b1101;
    localparam logic [3:0] OP_BZ    = 4'b1111;

    localparam logic [1:0] ACC_SRC_MEM = 2'b00;
    localparam logic [1:0] ACC_SRC_IMM = 2'b01;
    localparam logic [1:0] ACC_SRC_ALU = 2'b10;
    localparam logic [1:0] ACC_SRC_SLL = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // 1000..1110 are ALU ops; 1111 is BZ, which shares the top bit.
    function automatic logic is_alu(input logic [3:0] op);
        return op[3] && (op != OP_BZ);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op != 4'b0110) && (op != 4'b0111);
    endfunction

endpackage

// File: rtl/acc_multicycle_ctrl_timeout.sv
// Memory wait-state counter: counts cycles without mem_ready and flags expiry.
// o_expire fires in the wait cycle that would bring the count up to LIMIT; LIMIT = 0 disables it.
module acc_ctrl_timeout #(
    parameter int unsigned LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (LIMIT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/acc_multicycle_ctrl.sv
// Multi-cycle control FSM for the accumulator core: fetch/decode/mem/write-back
// sequencing with a req/ready memory handshake, traps and a retired-instruction count.
//
// state  | meaning
// IDLE   | parked, waiting for run
// FETCH  | instruction read from PC, IR/PC update on ready
// DECODE | classify opcode; branches and NOP retire here
// MEM    | operand read (LOAD/ALU) or SAVE write
// WB     | ACC write-back, retire
// TRAP   | sticky fault, exits only via reset
module acc_multicycle_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_acc_zero,
    input  logic               i_mem_ready,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic               o_addr_src,
    output logic               o_ir_write,
    output logic               o_mdr_write,
    output logic               o_pc_write,
    output logic               o_pc_src,
    output logic               o_acc_write,
    output logic [1:0]         o_acc_src,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_retire,
    output logic [CNT_W-1:0]   o_retired,
    output logic               o_trap,
    output logic [1:0]         o_trap_cause
);

    state_t            r_state;
    state_t            w_next;
    state_t            w_after;
    logic [3:0]        r_opcode;
    logic [3:0]        w_op;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_next;
    logic [CNT_W-1:0]  r_retired;
    logic              w_expire;
    logic              w_wait_en;
    logic              w_wait_clr;
    logic              w_unused_operand;

    // Operand bits only feed the datapath.
    assign w_unused_operand = ^i_instr[INSTR_W-5:0];

    // The IR is valid in DECODE; later states use the copy latched there.
    assign w_op    = (r_state == S_DECODE) ? i_instr[INSTR_W-1 -: 4] : r_opcode;
    assign w_after = i_run ? S_FETCH : S_IDLE;

    assign w_wait_en  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
    assign w_wait_clr = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));

    acc_ctrl_timeout #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_wait_clr),
        .i_en     (w_wait_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_opcode  <= OP_NOP;
            r_cause   <= CAUSE_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= w_op;
            end
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                r_cause <= w_cause_next;
            end
            if (o_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cause_next = CAUSE_NONE;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_addr_src   = 1'b0;
        o_ir_write   = 1'b0;
        o_mdr_write  = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = 1'b0;
        o_acc_write  = 1'b0;
        o_acc_src    = ACC_SRC_MEM;
        o_alu_op     = '0;
        o_retire     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_run) w_next = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_expire) begin
                    w_next       = S_TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (!is_legal(w_op)) begin
                    w_next       = S_TRAP;
                    w_cause_next = CAUSE_ILLEGAL;
                end else if (w_op == OP_NOP) begin
                    o_retire = 1'b1;
                    w_next   = w_after;
                end else if (w_op == OP_JUMP || w_op == OP_BZ) begin
                    o_pc_write = (w_op == OP_JUMP) ? 1'b1 : i_acc_zero;
                    o_pc_src   = 1'b1;
                    o_retire   = 1'b1;
                    w_next     = w_after;
                end else if (w_op == OP_LOADI || w_op == OP_SLL) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_MEM: begin
                o_mem_req  = 1'b1;
                o_addr_src = 1'b1;
                o_mem_we   = (w_op == OP_SAVE);
                if (i_mem_ready) begin
                    if (w_op == OP_SAVE) begin
                        o_retire = 1'b1;
                        w_next   = w_after;
                    end else begin
                        o_mdr_write = 1'b1;
                        w_next      = S_WB;
                    end
                end else if (w_expire) begin
                    w_next       = S_TRAP;
                    w_cause_next = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                o_acc_write = 1'b1;
                o_retire    = 1'b1;
                w_next      = w_after;
                if (is_alu(w_op)) begin
                    o_acc_src = ACC_SRC_ALU;
                    o_alu_op  = w_op[ALUOP_W-1:0];
                end else if (w_op == OP_LOADI) begin
                    o_acc_src = ACC_SRC_IMM;
                end else if (w_op == OP_SLL) begin
                    o_acc_src = ACC_SRC_SLL;
                end
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_trap       = (r_state == S_TRAP);
    assign o_trap_cause = r_cause;
    assign o_retired    = r_retired;

endmodule
